// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared types, constants and helpers for the fetch queue
package fetch_queue_pkg;

  localparam int PARCEL_W = 16;

  // Fetch/issue control state; pointer and count widths depend on DEPTH and live in the top.
  typedef struct packed {
    logic [31:0] fpc;
    logic [31:0] pc;
    logic        skip_low;
  } fetch_queue_reg_type;

  localparam fetch_queue_reg_type init_fetch_queue_reg = '{
    fpc:      32'h0,
    pc:       32'h0,
    skip_low: 1'b0
  };

  function automatic logic is_32bit(input logic [PARCEL_W-1:0] parcel);
    return parcel[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// rtl/fetch_queue_ram.sv - parcel storage, two adjacent write ports, two async read ports
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  logic [PARCEL_W-1:0] wdata0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  logic [PARCEL_W-1:0] wdata1,
  input  logic [AW-1:0]       raddr0,
  output logic [PARCEL_W-1:0] rdata0,
  input  logic [AW-1:0]       raddr1,
  output logic [PARCEL_W-1:0] rdata1
);

  logic [PARCEL_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue splitting memory words into 16/32-bit instructions
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_queue_reg_type r, rin;
  logic [PW-1:0]       head, tail, head_nxt, tail_nxt;
  logic [CW-1:0]       count, count_nxt, head_len, wr_len;
  logic [PARCEL_W-1:0] p0, p1;
  logic                head_32, mem_fire, instr_fire;
  logic                unused_bit0;

  assign unused_bit0 = jump_addr[0];

  assign head_32     = is_32bit(p0);
  assign head_len    = head_32 ? CW'(2) : CW'(1);
  assign wr_len      = r.skip_low ? CW'(1) : CW'(2);
  assign instr_valid = rst && (count >= head_len);
  assign instr       = instr_valid ? (head_32 ? {p1, p0} : {16'h0, p0}) : 32'h0;
  assign instr_pc    = r.pc;
  // Two free slots guarantee a full word always fits, so accepted data never overflows.
  assign mem_valid   = rst && !jump && (count <= CW'(DEPTH - 2));
  assign mem_addr    = r.fpc;
  assign mem_fire    = mem_valid && mem_ready;
  assign instr_fire  = instr_valid && instr_ready && !jump;

  fetch_queue_ram #(.DEPTH(DEPTH), .AW(PW)) u_ram (
    .clk    (clk),
    .we0    (mem_fire),
    .waddr0 (tail),
    .wdata0 (r.skip_low ? mem_rdata[31:16] : mem_rdata[15:0]),
    .we1    (mem_fire && !r.skip_low),
    .waddr1 (tail + PW'(1)),
    .wdata1 (mem_rdata[31:16]),
    .raddr0 (head),
    .rdata0 (p0),
    .raddr1 (head + PW'(1)),
    .rdata1 (p1)
  );

  always_comb begin
    rin       = r;
    head_nxt  = head;
    tail_nxt  = tail;
    count_nxt = count;
    if (jump) begin
      head_nxt     = '0;
      tail_nxt     = '0;
      count_nxt    = '0;
      rin.pc       = {jump_addr[31:1], 1'b0};
      rin.fpc      = {jump_addr[31:2], 2'b00};
      rin.skip_low = jump_addr[1];
    end else begin
      if (mem_fire) begin
        tail_nxt     = tail + wr_len[PW-1:0];
        rin.fpc      = r.fpc + 32'd4;
        rin.skip_low = 1'b0;
      end
      if (instr_fire) begin
        head_nxt = head + head_len[PW-1:0];
        rin.pc   = r.pc + (head_32 ? 32'd4 : 32'd2);
      end
      count_nxt = count + (mem_fire ? wr_len : CW'(0)) - (instr_fire ? head_len : CW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r          <= init_fetch_queue_reg;
      r.fpc      <= RESET_PC & 32'hFFFF_FFFC;
      r.pc       <= RESET_PC;
      r.skip_low <= RESET_PC[1];
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      r     <= rin;
      head  <= head_nxt;
      tail  <= tail_nxt;
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  logic [31:0] mem [0:127];
  assign mem_rdata = mem[mem_addr[8:2]];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int          n;
    logic [31:0] ins [3];
    logic [31:0] pcs [3];
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    exp_q.push_back(e);
  endtask

  task automatic add_vec(input logic [31:0] w0, input logic [31:0] w1, input int n,
                         input logic [31:0] i0, input logic [31:0] a0,
                         input logic [31:0] i1, input logic [31:0] a1,
                         input logic [31:0] i2, input logic [31:0] a2);
    vec_t v;
    v.w0 = w0; v.w1 = w1; v.n = n;
    v.ins[0] = i0; v.ins[1] = i1; v.ins[2] = i2;
    v.pcs[0] = a0; v.pcs[1] = a1; v.pcs[2] = a2;
    vecs.push_back(v);
  endtask

  // mode 0: all zero; mode 1: distinct 32-bit instruction per word
  task automatic fill_mem(input int mode);
    for (int i = 0; i < 128; i++)
      mem[i] = (mode == 0) ? 32'h0 : (32'h13 | (32'(i) << 7));
  endtask

  task automatic do_reset();
    rst = 1'b0; jump = 1'b0; mem_ready = 1'b0; instr_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain(input int budget);
    int   got  = 0;
    int   want = exp_q.size();
    exp_t e;
    for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
      #1;
      if (instr_valid && instr_ready) begin
        e = exp_q.pop_front();
        check("instr", instr, e.instr);
        check("instr_pc", instr_pc, e.pc);
        got++;
      end
      @(negedge clk);
    end
    check("drain_count", 32'(got), 32'(want));
  endtask

  initial begin
    int cnt;
    fill_mem(0);
    add_vec(32'h00000013, 32'h00100093, 2, 32'h00000013, 32'h0, 32'h00100093, 32'h4, 32'h0, 32'h0);
    add_vec(32'h45014505, 32'h00000000, 2, 32'h00004505, 32'h0, 32'h00004501, 32'h2, 32'h0, 32'h0);
    add_vec(32'h00134501, 32'h00000000, 2, 32'h00004501, 32'h0, 32'h00000013, 32'h2, 32'h0, 32'h0);
    add_vec(32'h00934505, 32'h45010010, 3, 32'h00004505, 32'h0, 32'h00100093, 32'h2, 32'h00004501, 32'h6);

    // Reset state, then the first request in the first cycle out of reset
    repeat (2) @(negedge clk);
    #1;
    check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    rst = 1'b1;
    #1;
    check("first_req_valid", {31'h0, mem_valid}, 32'h1);
    check("first_req_addr", mem_addr, 32'h0);

    foreach (vecs[v]) begin
      do_reset();
      fill_mem(0);
      mem[0] = vecs[v].w0;
      mem[1] = vecs[v].w1;
      mem_ready = 1'b1;
      instr_ready = 1'b1;
      for (int k = 0; k < vecs[v].n; k++) push(vecs[v].ins[k], vecs[v].pcs[k]);
      drain(30);
    end

    // Split 32-bit instruction waits for its second word
    do_reset();
    fill_mem(0);
    mem[0] = 32'h00134501;
    instr_ready = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("split_c_valid", {31'h0, instr_valid}, 32'h1);
    check("split_c_instr", instr, 32'h00004501);
    check("split_c_pc", instr_pc, 32'h0);
    @(negedge clk);
    #1;
    check("split_wait_valid", {31'h0, instr_valid}, 32'h0);
    check("split_hold_valid", {31'h0, mem_valid}, 32'h1);
    check("split_hold_addr", mem_addr, 32'h4);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("split_w_valid", {31'h0, instr_valid}, 32'h1);
    check("split_w_instr", instr, 32'h00000013);
    check("split_w_pc", instr_pc, 32'h2);

    // Redirect to an odd halfword while full
    do_reset();
    fill_mem(1);
    mem[64] = 32'h00134505;
    mem[65] = 32'h45010010;
    mem_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (!mem_valid) break;
    end
    check("full_mem_valid", {31'h0, mem_valid}, 32'h0);
    check("full_instr", instr, 32'h00000013);
    jump = 1'b1;
    jump_addr = 32'h00000102;
    #1;
    check("jump_mem_valid", {31'h0, mem_valid}, 32'h0);
    @(negedge clk);
    jump = 1'b0;
    #1;
    check("post_jump_valid", {31'h0, instr_valid}, 32'h0);
    check("post_jump_addr", mem_addr, 32'h00000100);
    check("post_jump_req", {31'h0, mem_valid}, 32'h1);
    check("post_jump_pc", instr_pc, 32'h00000102);
    instr_ready = 1'b1;
    push(32'h00100013, 32'h102);
    push(32'h00004501, 32'h106);
    drain(40);

    // Consumer stalled for 20 cycles: requests stop short of overflow, nothing lost
    do_reset();
    fill_mem(1);
    mem_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      check("stall_mem_valid", {31'h0, mem_valid}, {31'h0, cnt <= 6});
      check("stall_instr_valid", {31'h0, instr_valid}, {31'h0, cnt >= 2});
      if (cnt <= 6) cnt += 2;
      @(negedge clk);
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(32'h13 | (32'(i) << 7), 32'(4 * i));
    drain(60);

    // Jump together with a memory response and a consume
    do_reset();
    fill_mem(1);
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    instr_ready = 1'b1;
    jump = 1'b1;
    jump_addr = 32'h00000040;
    #1;
    check("j3_mem_valid", {31'h0, mem_valid}, 32'h0);
    check("j3_instr_valid", {31'h0, instr_valid}, 32'h1);
    @(negedge clk);
    jump = 1'b0;
    #1;
    check("j3_empty", {31'h0, instr_valid}, 32'h0);
    check("j3_pc", instr_pc, 32'h00000040);
    check("j3_addr", mem_addr, 32'h00000040);
    push(32'h13 | (32'd16 << 7), 32'h40);
    push(32'h13 | (32'd17 << 7), 32'h44);
    drain(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
